// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches under a credit limit, queues
// in-order responses tagged with their PC, and squashes stale responses after a redirect.
module instruction_prefetch_queue #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_resp_valid,
   input  logic [DATA_W-1:0] imem_resp_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] fetch_pc
);

   localparam int unsigned       PTR_W   = $clog2(DEPTH);
   localparam int unsigned       CNT_W   = PTR_W + 1;
   // Discards accumulate across back-to-back redirects, so give them headroom.
   localparam int unsigned       DISC_W  = CNT_W + 4;
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

   logic [DATA_W-1:0] instr_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem    [DEPTH];

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;
   logic [DISC_W-1:0] discard_q, discard_d;

   logic [CNT_W:0]    occupancy;
   logic [DISC_W-1:0] outstanding;
   logic              issue, resp_fire, resp_take, push, pop;

   always_comb begin
      occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
      outstanding    = DISC_W'(inflight_q) + discard_q;
      imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_C);
      issue          = imem_req_valid && imem_req_ready;
      // Responses with nothing outstanding are spurious and ignored.
      resp_fire      = imem_resp_valid && (outstanding != '0);
      resp_take      = resp_fire && (discard_q == '0);
      push           = resp_take && !redirect_valid;
      pop            = out_valid && out_ready && !redirect_valid;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         rd_ptr_d   = wr_ptr_q;
         count_d    = '0;
         inflight_d = '0;
         discard_d  = outstanding - DISC_W'(resp_fire);
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            resp_pc_d = resp_pc_q + STEP;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (resp_fire && !resp_take) begin
            discard_d = discard_q - DISC_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         case ({issue, resp_take})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         instr_mem[wr_ptr_q] <= imem_resp_data;
         pc_mem[wr_ptr_q]    <= resp_pc_q;
      end
   end

   assign out_valid     = (count_q != '0);
   assign out_instr     = instr_mem[rd_ptr_q];
   assign out_pc        = pc_mem[rd_ptr_q];
   assign imem_req_addr = fetch_pc_q;
   assign fetch_pc      = fetch_pc_q;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue against a queue-level reference model
// with an in-order memory that answers outstanding fetches.
module tb_instruction_prefetch_queue;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int unsigned PC_STEP  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic              imem_req_valid;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_req_ready = 1'b0;
   logic              imem_resp_valid = 1'b0;
   logic [DATA_W-1:0] imem_resp_data = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] fetch_pc;

   always #5 clk = ~clk;

   instruction_prefetch_queue #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_ready       (out_ready),
      .fetch_pc        (fetch_pc)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      q[$];      // instructions visible to the consumer
   entry_t      mem_q[$];  // fetches awaiting a memory response
   int          m_inflight;
   int          m_discard;
   logic [31:0] m_fetch_pc;
   logic [31:0] m_resp_pc;
   bit          m_valid = 1'b0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy,
                       input bit resp, input bit ordy);
      bit     req_exp, issue, resp_fire;
      entry_t m;
      @(negedge clk);
      reset           = rst;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      imem_req_ready  = rdy;
      out_ready       = ordy;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (resp && mem_q.size() > 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_q[0].instr;
      end else if (resp && $urandom_range(0, 7) == 0) begin
         imem_resp_valid = 1'b1;  // spurious response with nothing outstanding
      end
      #1;
      req_exp = !rst && !redir && (q.size() + m_inflight < DEPTH);
      if (m_valid) begin
         check_eq("req_valid", 64'(imem_req_valid), 64'(req_exp));
         check_eq("req_addr", 64'(imem_req_addr), 64'(m_fetch_pc));
         check_eq("fetch_pc", 64'(fetch_pc), 64'(m_fetch_pc));
         check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check_eq("out_pc", 64'(out_pc), 64'(q[0].pc));
            check_eq("out_instr", 64'(out_instr), 64'(q[0].instr));
         end
      end
      if (rst) begin
         q.delete();
         mem_q.delete();
         m_inflight = 0;
         m_discard  = 0;
         m_fetch_pc = RESET_PC;
         m_resp_pc  = RESET_PC;
         m_valid    = 1'b1;
      end else if (m_valid) begin
         issue     = req_exp && rdy;
         resp_fire = imem_resp_valid && (m_inflight + m_discard > 0);
         m         = '0;
         if (resp_fire) m = mem_q.pop_front();
         if (redir) begin
            q.delete();
            m_discard  = m_inflight + m_discard - (resp_fire ? 1 : 0);
            m_inflight = 0;
            m_fetch_pc = rpc;
            m_resp_pc  = rpc;
         end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (resp_fire) begin
               if (m_discard > 0) begin
                  m_discard--;
               end else begin
                  q.push_back('{pc: m_resp_pc, instr: m.instr});
                  m_resp_pc += PC_STEP;
                  m_inflight--;
               end
            end
            if (issue) begin
               mem_q.push_back('{pc: m_fetch_pc, instr: $urandom});
               m_inflight++;
               m_fetch_pc += PC_STEP;
            end
         end
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 32'h0000_0100;
         1:       return 32'hFFFF_FFF8;
         default: return $urandom & 32'hFFFF_FFFC;
      endcase
   endfunction

   initial begin
      // Streaming with single-cycle memory and a ready consumer.
      repeat (2) step(1, 0, 0, 0, 0, 0);
      repeat (40) step(0, 0, 0, 1, 1, 1);

      // Stalled consumer: credits run out, then one pop frees one issue.
      repeat (12) step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1);
      repeat (6) step(0, 0, 0, 1, 1, 0);

      // Redirect with two fetches in flight; stale responses must vanish.
      step(1, 0, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 1, 0, 1);
      step(0, 1, 32'h100, 1, 0, 1);
      repeat (20) step(0, 0, 0, 1, 1, 1);

      // Redirect coinciding with a response and a pop, then back-to-back redirects.
      step(0, 1, 32'h200, 1, 1, 1);
      step(0, 1, 32'h300, 1, 1, 1);
      repeat (15) step(0, 0, 0, 1, 1, 1);

      // Address wrap at the top of the space.
      step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
      repeat (15) step(0, 0, 0, 1, 1, 1);

      // Reset mid-operation with entries queued and fetches outstanding.
      repeat (2) step(0, 0, 0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0, 1, 0);
      repeat (2) step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 1, 1);
      repeat (10) step(0, 0, 0, 1, 1, 1);

      // Random mix of everything.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, pick_target(),
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
